// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: iteration count,
// counter width and FSM state encodings.
package iter_divider_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, subtract
// the divisor when no borrow occurs, and shift the quotient bit into dvd_o.
module div_step
  import iter_divider_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dvd_o
);

  logic [W:0] trial;
  logic       no_borrow;

  assign trial     = {rem_i, dvd_i[W-1]};
  assign no_borrow = (trial >= {1'b0, dsr_i});
  // trial < 2*divisor, so the true difference always fits in W bits
  assign rem_o     = no_borrow ? (trial[W-1:0] - dsr_i) : trial[W-1:0];
  assign dvd_o     = {dvd_i[W-2:0], no_borrow};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned divider for the EX stage: magnitude restoring
// division over 32 cycles, with sign fix-up and single-cycle special cases.
//
// state | meaning
// IDLE  | waiting for div_start; captures operands
// CALC  | one restoring step per cycle, counter 0..31
// SIGN  | apply result signs, register outputs
// DONE  | div_done pulse, then back to IDLE
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   div_s1,
  input  logic [DATA_WIDTH:0]   div_s2,
  input  logic                  div_start,
  input  logic                  div_flush,
  output logic [DATA_WIDTH:0]   div_quotient,
  output logic [DATA_WIDTH:0]   div_remainder,
  output logic                  div_done,
  output logic                  div_stall_req
);

  localparam int DW  = DATA_WIDTH;
  localparam int DWX = DATA_WIDTH + 1;
  localparam logic [DW-1:0]    ONE    = DW'(1);
  localparam logic [DWX-1:0]   ONE_X  = DWX'(1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DIV_ITER - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [DW-1:0]    dsr_q, dsr_d;
  logic [DW-1:0]    rem_q, rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [DW:0]      quo_q, quo_d;
  logic [DW:0]      rmd_q, rmd_d;

  logic [DW-1:0]    mag_s1, mag_s2;
  logic [DW-1:0]    step_rem, step_dvd;
  logic             ovf;

  assign mag_s1 = div_s1[DW] ? (~div_s1[DW-1:0] + ONE) : div_s1[DW-1:0];
  assign mag_s2 = div_s2[DW] ? (~div_s2[DW-1:0] + ONE) : div_s2[DW-1:0];
  // most-negative dividend over -1 cannot be represented after sign fix-up
  assign ovf    = (div_s1 == {2'b11, {(DW-1){1'b0}}}) && (&div_s2);

  div_step #(.W(DW)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    if (div_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_start) begin
            q_neg_d = div_s1[DW] ^ div_s2[DW];
            r_neg_d = div_s1[DW];
            dvd_d   = mag_s1;
            dsr_d   = mag_s2;
            rem_d   = '0;
            cnt_d   = '0;
            if (div_s2 == '0) begin
              quo_d   = '1;
              rmd_d   = div_s1;
              state_d = DONE;
            end else if (ovf) begin
              quo_d   = div_s1;
              rmd_d   = '0;
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_TC) state_d = SIGN;
        end
        SIGN: begin
          quo_d   = q_neg_q ? (~{1'b0, dvd_q} + ONE_X) : {1'b0, dvd_q};
          rmd_d   = r_neg_q ? (~{1'b0, rem_q} + ONE_X) : {1'b0, rem_q};
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign div_done      = (state_q == DONE);
  assign div_stall_req = div_start & ~div_flush & (state_q != DONE);
  assign div_quotient  = quo_q;
  assign div_remainder = rmd_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: vector table plus random operands
// against a scoreboard, with flush and mid-operation reset sequences.
module tb_iter_divider;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [DW:0] div_s1, div_s2;
  logic        div_start, div_flush;
  logic [DW:0] div_quotient, div_remainder;
  logic        div_done, div_stall_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW:0] s1;
    logic [DW:0] s2;
    logic [DW:0] q;
    logic [DW:0] r;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [DW:0] q;
    logic [DW:0] r;
    int          cyc;
  } exp_t;

  vec_t        vecs[12];
  exp_t        sb_q[$];
  logic [DW:0] last_q, last_r;

  iter_divider #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .div_s1        (div_s1),
    .div_s2        (div_s2),
    .div_start     (div_start),
    .div_flush     (div_flush),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_done      (div_done),
    .div_stall_req (div_stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model built on native signed 33-bit division.
  function automatic void ref_div(input logic [DW:0] a, input logic [DW:0] b,
                                  output logic [DW:0] q, output logic [DW:0] r,
                                  output int cyc);
    logic signed [DW:0] sa, sb;
    if (b == '0) begin
      q = '1; r = a; cyc = 2;
    end else if (a == 33'h1_8000_0000 && b == 33'h1_FFFF_FFFF) begin
      q = a; r = '0; cyc = 2;
    end else begin
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
      cyc = 35;
    end
  endfunction

  // Called just after a falling edge; returns at the falling edge of the done cycle.
  task automatic do_div(input logic [DW:0] s1, input logic [DW:0] s2,
                        input logic [DW:0] q, input logic [DW:0] r, input int cyc);
    exp_t e;
    int   n;
    bit   seen;
    div_s1    = s1;
    div_s2    = s2;
    div_start = 1'b1;
    div_flush = 1'b0;
    sb_q.push_back('{q: q, r: r, cyc: cyc});
    #1;
    if (div_done) begin
      chk_bit("stall_in_done", div_stall_req, 1'b0);
      @(negedge clk);
      #1;
    end
    chk_bit("stall_capture", div_stall_req, 1'b1);
    chk_bit("done_capture", div_done, 1'b0);
    n = 1;
    seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (div_done) begin
        seen = 1;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=done expected=no_done");
        end else begin
          e = sb_q.pop_front();
          chk("quotient", div_quotient, e.q);
          chk("remainder", div_remainder, e.r);
          chk_int("latency", n, e.cyc);
          chk_bit("stall_done", div_stall_req, 1'b0);
          last_q = e.q;
          last_r = e.r;
        end
      end else if (div_stall_req !== 1'b1) begin
        checks++; errors++;
        $display("FAIL stall_busy actual=%b expected=1 cycle=%0d", div_stall_req, n);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none expected=done_by_cycle_%0d", cyc);
      sb_q.delete();
    end
  endtask

  task automatic idle(input int n);
    div_start = 1'b0;
    div_flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_bit("no_spurious_done", div_done, 1'b0);
    end
  endtask

  initial begin
    logic [DW:0] a, b, q, r;
    int          cyc;

    vecs[0]  = '{s1: 33'h0_0000_0064, s2: 33'h1_FFFF_FFF9, q: 33'h1_FFFF_FFF2, r: 33'h0_0000_0002, cyc: 35};
    vecs[1]  = '{s1: 33'h0_FFFF_FFFF, s2: 33'h0_0000_0010, q: 33'h0_0FFF_FFFF, r: 33'h0_0000_000F, cyc: 35};
    vecs[2]  = '{s1: 33'h0_0000_002A, s2: 33'h0_0000_0000, q: 33'h1_FFFF_FFFF, r: 33'h0_0000_002A, cyc: 2};
    vecs[3]  = '{s1: 33'h1_8000_0000, s2: 33'h1_FFFF_FFFF, q: 33'h1_8000_0000, r: 33'h0_0000_0000, cyc: 2};
    vecs[4]  = '{s1: 33'h1_FFFF_FFF9, s2: 33'h0_0000_0002, q: 33'h1_FFFF_FFFD, r: 33'h1_FFFF_FFFF, cyc: 35};
    vecs[5]  = '{s1: 33'h1_FFFF_FF9C, s2: 33'h1_FFFF_FFF9, q: 33'h0_0000_000E, r: 33'h1_FFFF_FFFE, cyc: 35};
    vecs[6]  = '{s1: 33'h0_8000_0000, s2: 33'h0_FFFF_FFFF, q: 33'h0_0000_0000, r: 33'h0_8000_0000, cyc: 35};
    vecs[7]  = '{s1: 33'h0_0000_0005, s2: 33'h0_0000_0000, q: 33'h1_FFFF_FFFF, r: 33'h0_0000_0005, cyc: 2};
    vecs[8]  = '{s1: 33'h0_0000_0007, s2: 33'h0_0000_0007, q: 33'h0_0000_0001, r: 33'h0_0000_0000, cyc: 35};
    vecs[9]  = '{s1: 33'h1_8000_0000, s2: 33'h0_0000_0001, q: 33'h1_8000_0000, r: 33'h0_0000_0000, cyc: 35};
    vecs[10] = '{s1: 33'h0_0000_0000, s2: 33'h0_0000_0005, q: 33'h0_0000_0000, r: 33'h0_0000_0000, cyc: 35};
    vecs[11] = '{s1: 33'h0_FFFF_FFFF, s2: 33'h0_0000_0001, q: 33'h0_FFFF_FFFF, r: 33'h0_0000_0000, cyc: 35};

    rst       = 1'b1;
    div_start = 1'b0;
    div_flush = 1'b0;
    div_s1    = '0;
    div_s2    = '0;
    last_q    = '0;
    last_r    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_quotient", div_quotient, '0);
    chk("reset_remainder", div_remainder, '0);
    chk_bit("reset_done", div_done, 1'b0);
    chk_bit("reset_stall", div_stall_req, 1'b0);

    // Table vectors issued back to back, start held across each done pulse.
    for (int i = 0; i < 12; i++)
      do_div(vecs[i].s1, vecs[i].s2, vecs[i].q, vecs[i].r, vecs[i].cyc);
    idle(3);
    chk("hold_quotient", div_quotient, last_q);
    chk("hold_remainder", div_remainder, last_r);

    for (int i = 0; i < 10; i++) begin
      a = {1'b0, 32'($urandom)};
      b = {1'b0, 32'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(1, 500))};
      if ($urandom_range(0, 1) == 1) begin
        a[DW] = a[DW-1];
        b[DW] = b[DW-1];
      end
      ref_div(a, b, q, r, cyc);
      do_div(a, b, q, r, cyc);
      idle(1);
    end

    // Flush at CALC iteration 10 (cycle 12): no done, outputs retained.
    @(negedge clk);
    div_s1    = 33'h0_0000_03E8;
    div_s2    = 33'h0_0000_0003;
    div_start = 1'b1;
    for (int c = 2; c <= 12; c++) @(negedge clk);
    div_flush = 1'b1;
    #1;
    chk_bit("stall_flush", div_stall_req, 1'b0);
    @(negedge clk);
    div_flush = 1'b0;
    div_start = 1'b0;
    chk_bit("done_after_flush", div_done, 1'b0);
    idle(40);
    chk("flush_hold_quotient", div_quotient, last_q);
    chk("flush_hold_remainder", div_remainder, last_r);
    ref_div(33'h0_0000_03E8, 33'h0_0000_0003, q, r, cyc);
    do_div(33'h0_0000_03E8, 33'h0_0000_0003, q, r, cyc);
    idle(2);

    // Reset mid-CALC with start still asserted discards the operation.
    div_s1    = 33'h1_FFFF_F000;
    div_s2    = 33'h0_0000_0013;
    div_start = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    chk("rst_quotient", div_quotient, '0);
    chk("rst_remainder", div_remainder, '0);
    chk_bit("rst_done", div_done, 1'b0);
    idle(40);
    ref_div(33'h1_FFFF_F000, 33'h0_0000_0013, q, r, cyc);
    do_div(33'h1_FFFF_F000, 33'h0_0000_0013, q, r, cyc);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
